// File: rtl/result_bcd_reader.sv
// Captures calculator results on a rising done_i, converts them to packed BCD by double dabble
// and holds them under a valid/ack handshake. RESULT_BCD_REM_CONVERT_EN also converts the remainder.
module result_bcd_reader #(
  parameter int width  = 8,
  parameter int DIGITS = 5
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [2*width-1:0]    res_i,
  input  logic [2*width-1:0]    rem_i,
  input  logic                  done_i,
  input  logic                  ack_i,
  output logic [4*DIGITS-1:0]   res_bcd_o,
  output logic [4*DIGITS-1:0]   rem_bcd_o,
  output logic                  valid_o,
  output logic                  busy_o,
  output logic                  drop_o
);
  // state    | meaning
  // IDLE     | waiting for a done_i rise
  // CONV_RES | shifting the result through the BCD accumulator
  // CONV_REM | shifting the remainder through the BCD accumulator
  // VALID    | BCD outputs held until ack_i

  localparam int RW = 2 * width;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(RW);
  localparam logic [CW-1:0] LAST = CW'(RW - 1);

`ifdef RESULT_BCD_REM_CONVERT_EN
  typedef enum logic [1:0] {IDLE, CONV_RES, CONV_REM, VALID} state_t;
`else
  typedef enum logic [1:0] {IDLE, CONV_RES, VALID} state_t;
`endif

  state_t          state_q, state_d;
  logic            done_q, done_d;
  logic [RW-1:0]   res_sh_q, res_sh_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   res_bcd_q, res_bcd_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;
  logic            start;
  logic [BW-1:0]   adj;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] a);
    logic [BW-1:0] r;
    r = a;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] >= 4'd5) r[4*i +: 4] = a[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef RESULT_BCD_REM_CONVERT_EN
  logic [RW-1:0] rem_sh_q, rem_sh_d;
  logic [BW-1:0] rem_bcd_q, rem_bcd_d;
`endif

  always_comb begin
    state_d   = state_q;
    done_d    = done_i;
    res_sh_d  = res_sh_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    res_bcd_d = res_bcd_q;
    drop_d    = drop_q;
`ifdef RESULT_BCD_REM_CONVERT_EN
    rem_sh_d  = rem_sh_q;
    rem_bcd_d = rem_bcd_q;
`endif
    start = done_i & ~done_q;
    adj   = add3(acc_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          res_sh_d = res_i;
`ifdef RESULT_BCD_REM_CONVERT_EN
          rem_sh_d = rem_i;
`endif
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CONV_RES;
        end
      end
      CONV_RES: begin
        acc_d    = {adj[BW-2:0], res_sh_q[RW-1]};
        res_sh_d = {res_sh_q[RW-2:0], 1'b0};
        cnt_d    = cnt_q + 1'b1;
        if (start) drop_d = 1'b1;
        if (cnt_q == LAST) begin
          res_bcd_d = acc_d;
          acc_d     = '0;
          cnt_d     = '0;
`ifdef RESULT_BCD_REM_CONVERT_EN
          state_d   = CONV_REM;
`else
          state_d   = VALID;
`endif
        end
      end
`ifdef RESULT_BCD_REM_CONVERT_EN
      CONV_REM: begin
        acc_d    = {adj[BW-2:0], rem_sh_q[RW-1]};
        rem_sh_d = {rem_sh_q[RW-2:0], 1'b0};
        cnt_d    = cnt_q + 1'b1;
        if (start) drop_d = 1'b1;
        if (cnt_q == LAST) begin
          rem_bcd_d = acc_d;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = VALID;
        end
      end
`endif
      VALID: begin
        if (ack_i) begin
          if (start) begin
            // Same-cycle ack frees the holding slot, so the new result is taken, not dropped.
            res_sh_d = res_i;
`ifdef RESULT_BCD_REM_CONVERT_EN
            rem_sh_d = rem_i;
`endif
            acc_d   = '0;
            cnt_d   = '0;
            state_d = CONV_RES;
          end else begin
            state_d = IDLE;
          end
        end else if (start) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef RESULT_BCD_REM_CONVERT_EN
    busy_d  = (state_d == CONV_RES) || (state_d == CONV_REM);
`else
    busy_d  = (state_d == CONV_RES);
`endif
    valid_d = (state_d == VALID);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      res_sh_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      res_bcd_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      drop_q    <= 1'b0;
`ifdef RESULT_BCD_REM_CONVERT_EN
      rem_sh_q  <= '0;
      rem_bcd_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      res_sh_q  <= res_sh_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      res_bcd_q <= res_bcd_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      drop_q    <= drop_d;
`ifdef RESULT_BCD_REM_CONVERT_EN
      rem_sh_q  <= rem_sh_d;
      rem_bcd_q <= rem_bcd_d;
`endif
    end
  end

`ifdef RESULT_BCD_REM_CONVERT_EN
  assign rem_bcd_o = rem_bcd_q;
`else
  logic unused_rem;
  assign unused_rem = ^rem_i;
  assign rem_bcd_o  = '0;
`endif

  assign res_bcd_o = res_bcd_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign drop_o    = drop_q;

endmodule
